btb_ways: RTL and testbench
===========================

# btb_ways

Storage and lookup side of the 2-way set-associative branch target buffer. It holds valid/tag/target/2-bit counter for 8 sets × 2 ways. It performs the IF-stage lookup and drives the hit-way signals into the LRU block. It also performs EX-stage update/allocation, picking the victim way from the LRU block's per-set bit.

## Interface
- `SET_W`, 3: index width; 2^SET_W sets; index = `pc[SET_W+1:2]`
- `PC_W`, 32: PC and target width; tag = `pc[PC_W-1:SET_W+2]`
- `clk` in 1: clock, rising edge
- `rst_n` in 1: synchronous, active-low reset
- `if_valid` in 1: IF lookup request
- `if_pc` in PC_W: fetch PC
- `predict_hit` out 1: tag hit in either way
- `predict_taken` out 1: hit and counter MSB = 1
- `predict_target` out PC_W: target of hit way; 0 on miss
- `read_index` out SET_W: `if_pc` index, always driven
- `branch1_used` out 1: IF hit in way 1
- `branch2_used` out 1: IF hit in way 2
- `ex_valid` in 1: resolved branch from EX
- `ex_pc` in PC_W: branch PC
- `ex_taken` in 1: resolved direction
- `ex_target` in PC_W: resolved target
- `update` out 1: entry touched this cycle (hit, or allocation)
- `update_index` out SET_W: `ex_pc` index
- `update_branch1` out 1: EX hit in way 1
- `update_branch2` out 1: EX hit in way 2
- `lru_write_bit` in 1: LRU bit of `update_index`; 0 → victim is way 1, 1 → victim is way 2
- `flush` in 1: start invalidate-all
- `flush_busy` out 1: invalidate walk in progress

## Operation
- **Lookup** (combinational from array):
  - Way k hits when `valid[k] && tag[k] == tag(if_pc) && if_valid && !flush_busy`.
  - If both ways hit, way 1 wins; only `branch1_used` is asserted.
  - `predict_taken` = hit && `ctr[1]`.
- **Update**, on a clock edge with `ex_valid && !flush_busy`:
  - EX hit in way k:
    - `ctr` saturates (+1 if taken, −1 if not).
    - `target` ← `ex_target` if taken.
    - `update` = 1, `update_branchk` = 1.
  - EX miss and taken:
    - Allocate way (`lru_write_bit` ? 2 : 1).
    - valid ← 1, tag ← tag(ex_pc), target ← `ex_target`, ctr ← 2'b10.
    - `update` = 1, `update_branch1` = `update_branch2` = 0.
  - EX miss and not taken: no write, `update` = 0.
- **FSM** states IDLE and FLUSH, with a SET_W-bit counter `fptr`.
  - IDLE → FLUSH on `flush`; `fptr` ← 0.
  - In FLUSH, each cycle clears `valid` of both ways in set `fptr`, then increments `fptr`.
  - FLUSH → IDLE after set 2^SET_W−1 is cleared; `fptr` wraps to 0.
  - `flush` asserted while in FLUSH restarts the walk (`fptr` ← 0).
  - `flush_busy` = (state == FLUSH).
  - While busy: lookups miss, all `*_used` and `update*` signals are 0, and EX updates are dropped.
- **Reset** (`rst_n` = 0 at edge):
  - All valid bits ← 0, ctr ← 0, state ← IDLE, `fptr` ← 0.
  - Tag and target contents are don't-care.
  - Outputs after reset: `predict_hit`/`predict_taken` = 0, `predict_target` = 0, `flush_busy` = 0, `update` = 0.
- Reset asserted mid-flush aborts the walk into IDLE with all entries invalid.

## Timing
- Lookup is 0-cycle: outputs are valid in the same cycle as `if_pc`.
- Update is written at the edge ending the `ex_valid` cycle and is visible to lookups in the next cycle.
- `update*` signals are combinational in the `ex_valid` cycle, so the LRU block samples them at the same edge.
- Same-cycle IF and EX to the same set: lookup sees pre-update contents (unless bypass is enabled).
- Flush takes exactly 2^SET_W cycles (8 by default).
  - `flush_busy` rises the cycle after `flush`.
  - `flush_busy` falls 8 cycles later.

## Configuration
- `BTB_BYPASS_EN` defined:
  - If the EX write this cycle targets the same set and tag as `if_pc`, lookup returns the write's data.
  - This covers counter, target and way; `branchk_used` names the written way.
  - Forwarded hits take priority over array hits.
- `BTB_BYPASS_EN` undefined: no forwarding; lookup sees the array only.

## Test plan
- Reset, then lookup `if_pc`=0x100 → `predict_hit`=0, `predict_target`=0, `branch1_used`=`branch2_used`=0.
- EX `ex_pc`=0x100, taken, target 0x400, `lru_write_bit`=0 → way 1 allocated, `update`=1, `update_branch1`=0; next-cycle lookup 0x100 → hit, taken, target 0x400, `branch1_used`=1.
- Same set, different tag 0x120, taken, target 0x800, `lru_write_bit`=1 → way 2 allocated; lookups of 0x100 and 0x120 hit ways 1 and 2 respectively.
- Three not-taken updates of 0x100 → counter 10→01→00→00 (saturates); `predict_taken`=0 after the first; `update_branch1`=1 each time; target stays 0x400.
- `flush` pulse → `flush_busy` high for exactly 8 cycles; EX update during busy is dropped with `update`=0; afterwards all lookups miss.
- Same-cycle IF 0x140 and EX allocate 0x140 → miss without `BTB_BYPASS_EN`; hit, target forwarded with `BTB_BYPASS_EN`. Reset asserted mid-flush → `flush_busy`=0 next cycle.

Source files
------------

// File: rtl/btb_ways_if.sv
// Bus bundle between the fetch/execute stages (master) and the BTB storage (slave).
// Carries the IF lookup, the EX update/allocation, the LRU hand-off and the flush control.
interface btb_ways_if #(
    parameter int SET_W = 3,
    parameter int PC_W  = 32
);
    // Handshake: if_valid and ex_valid are single-cycle qualifiers with no ready.
    // The BTB never stalls. Lookup results and update* are combinational in the same cycle.
    // Writes land at the edge that ends an accepted ex_valid cycle.
    logic              if_valid;
    logic [PC_W-1:0]   if_pc;
    logic              predict_hit;
    logic              predict_taken;
    logic [PC_W-1:0]   predict_target;
    logic [SET_W-1:0]  read_index;
    logic              branch1_used;
    logic              branch2_used;
    logic              ex_valid;
    logic [PC_W-1:0]   ex_pc;
    logic              ex_taken;
    logic [PC_W-1:0]   ex_target;
    logic              update;
    logic [SET_W-1:0]  update_index;
    logic              update_branch1;
    logic              update_branch2;
    logic              lru_write_bit;
    logic              flush;
    logic              flush_busy;

    modport master (
        output if_valid, if_pc, ex_valid, ex_pc, ex_taken, ex_target, lru_write_bit, flush,
        input  predict_hit, predict_taken, predict_target, read_index, branch1_used,
               branch2_used, update, update_index, update_branch1, update_branch2, flush_busy
    );

    modport slave (
        input  if_valid, if_pc, ex_valid, ex_pc, ex_taken, ex_target, lru_write_bit, flush,
        output predict_hit, predict_taken, predict_target, read_index, branch1_used,
               branch2_used, update, update_index, update_branch1, update_branch2, flush_busy
    );
endinterface

// File: rtl/btb_ways.sv
// 2-way set-associative BTB storage: IF lookup, EX update/allocate, and a flush walk.
// Define BTB_BYPASS_EN to forward a same-cycle EX write to a matching IF lookup.
module btb_ways #(
    parameter int SET_W = 3,
    parameter int PC_W  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    btb_ways_if.slave  bus,
    output logic       dbg_state_o
);
    localparam int SETS  = 1 << SET_W;
    localparam int TAG_W = PC_W - SET_W - 2;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [SET_W-1:0]  fptr_q, fptr_d;
    logic              busy;

    logic [SETS-1:0]   valid_q  [2];
    logic [TAG_W-1:0]  tag_q    [2][SETS];
    logic [PC_W-1:0]   target_q [2][SETS];
    logic [1:0]        ctr_q    [2][SETS];

    logic [SET_W-1:0]  rd_idx, up_idx;
    logic [TAG_W-1:0]  rd_tag, up_tag;
    logic              look_en, arr_hit1, arr_hit2;
    logic              ex_en, ex_hit1, ex_hit2, ex_alloc, wr_en, wr_way;
    logic [1:0]        old_ctr, wr_ctr;
    logic [PC_W-1:0]   wr_target;
    logic              fwd;
    logic              hit, hit_way;
    logic [1:0]        hit_ctr;
    logic [PC_W-1:0]   hit_target;

    assign busy        = (state_q == FLUSH);
    assign dbg_state_o = state_q;

    // ---------------- flush walk FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fptr_q  <= '0;
        end else begin
            state_q <= state_d;
            fptr_q  <= fptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fptr_d  = fptr_q;
        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    state_d = FLUSH;
                    fptr_d  = '0;
                end
            end
            FLUSH: begin
                if (bus.flush) begin
                    fptr_d = '0;
                end else if (&fptr_q) begin
                    state_d = IDLE;
                    fptr_d  = '0;
                end else begin
                    fptr_d = fptr_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                fptr_d  = '0;
            end
        endcase
    end

    // ---------------- EX update / allocation ----------------
    always_comb begin
        up_idx   = bus.ex_pc[SET_W+1:2];
        up_tag   = bus.ex_pc[PC_W-1:SET_W+2];
        ex_en    = bus.ex_valid && !busy;
        ex_hit1  = ex_en && valid_q[0][up_idx] && (tag_q[0][up_idx] == up_tag);
        ex_hit2  = ex_en && !ex_hit1 && valid_q[1][up_idx] && (tag_q[1][up_idx] == up_tag);
        ex_alloc = ex_en && !ex_hit1 && !ex_hit2 && bus.ex_taken;
        wr_en    = ex_hit1 || ex_hit2 || ex_alloc;
        // Way 1 wins a double hit; on a miss the LRU bit names the victim.
        wr_way   = ex_hit1 ? 1'b0 : (ex_hit2 ? 1'b1 : bus.lru_write_bit);
        old_ctr  = ctr_q[wr_way][up_idx];
        if (ex_alloc) begin
            wr_ctr = 2'b10;
        end else if (bus.ex_taken) begin
            wr_ctr = (old_ctr == 2'b11) ? 2'b11 : old_ctr + 2'd1;
        end else begin
            wr_ctr = (old_ctr == 2'b00) ? 2'b00 : old_ctr - 2'd1;
        end
        wr_target = bus.ex_taken ? bus.ex_target : target_q[wr_way][up_idx];
    end

    assign bus.update         = wr_en;
    assign bus.update_index   = up_idx;
    assign bus.update_branch1 = ex_hit1;
    assign bus.update_branch2 = ex_hit2;
    assign bus.flush_busy     = busy;

    // ---------------- IF lookup ----------------
    always_comb begin
        rd_idx   = bus.if_pc[SET_W+1:2];
        rd_tag   = bus.if_pc[PC_W-1:SET_W+2];
        look_en  = bus.if_valid && !busy;
        arr_hit1 = look_en && valid_q[0][rd_idx] && (tag_q[0][rd_idx] == rd_tag);
        arr_hit2 = look_en && valid_q[1][rd_idx] && (tag_q[1][rd_idx] == rd_tag);
`ifdef BTB_BYPASS_EN
        fwd      = look_en && wr_en && (up_idx == rd_idx) && (up_tag == rd_tag);
`else
        fwd      = 1'b0;
`endif
        hit        = 1'b0;
        hit_way    = 1'b0;
        hit_ctr    = 2'b00;
        hit_target = '0;
        if (fwd) begin
            hit        = 1'b1;
            hit_way    = wr_way;
            hit_ctr    = wr_ctr;
            hit_target = wr_target;
        end else if (arr_hit1) begin
            hit        = 1'b1;
            hit_way    = 1'b0;
            hit_ctr    = ctr_q[0][rd_idx];
            hit_target = target_q[0][rd_idx];
        end else if (arr_hit2) begin
            hit        = 1'b1;
            hit_way    = 1'b1;
            hit_ctr    = ctr_q[1][rd_idx];
            hit_target = target_q[1][rd_idx];
        end
    end

    assign bus.predict_hit    = hit;
    assign bus.predict_taken  = hit && hit_ctr[1];
    assign bus.predict_target = hit_target;
    assign bus.read_index     = rd_idx;
    assign bus.branch1_used   = hit && !hit_way;
    assign bus.branch2_used   = hit && hit_way;

    // ---------------- storage ----------------
    // Flush clears one set per cycle; EX writes cannot collide because they are dropped while busy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            for (int s = 0; s < SETS; s++) begin
                ctr_q[0][s] <= 2'b00;
                ctr_q[1][s] <= 2'b00;
            end
        end else if (busy) begin
            valid_q[0][fptr_q] <= 1'b0;
            valid_q[1][fptr_q] <= 1'b0;
        end else if (wr_en) begin
            valid_q[wr_way][up_idx] <= 1'b1;
            ctr_q[wr_way][up_idx]   <= wr_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_way][up_idx]    <= up_tag;
            target_q[wr_way][up_idx] <= wr_target;
        end
    end
endmodule

// File: tb/tb_btb_ways.sv
// Directed bench for btb_ways: an abstract BTB model checked on every cycle plus hand-computed expectations.
// Build with +define+BTB_BYPASS_EN to exercise the forwarding path.
module tb_btb_ways;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic dbg_state;
    int   n_chk = 0;
    int   n_err = 0;

    btb_ways_if #(.SET_W(3), .PC_W(32)) bus ();

    btb_ways #(.SET_W(3), .PC_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- abstract model: arrays of entries plus a busy countdown ----------------
    logic        m_valid [2][8];
    logic [26:0] m_tag   [2][8];
    logic [31:0] m_tgt   [2][8];
    int          m_ctr   [2][8];
    int          m_busy_left = 0;
    bit          m_init = 0;

    function automatic void model_ex(output bit wr, output int way, output int nctr,
                                     output logic [31:0] ntgt, output bit h1, output bit h2);
        int s = int'(bus.ex_pc[4:2]);
        logic [26:0] t = bus.ex_pc[31:5];
        wr = 0; way = 0; nctr = 0; ntgt = 32'h0; h1 = 0; h2 = 0;
        if (!bus.ex_valid || m_busy_left > 0) return;
        h1 = m_valid[0][s] && (m_tag[0][s] == t);
        h2 = !h1 && m_valid[1][s] && (m_tag[1][s] == t);
        if (h1 || h2) begin
            wr   = 1;
            way  = h1 ? 0 : 1;
            nctr = bus.ex_taken ? ((m_ctr[way][s] >= 3) ? 3 : m_ctr[way][s] + 1)
                                : ((m_ctr[way][s] <= 0) ? 0 : m_ctr[way][s] - 1);
            ntgt = bus.ex_taken ? bus.ex_target : m_tgt[way][s];
        end else if (bus.ex_taken) begin
            wr   = 1;
            way  = bus.lru_write_bit ? 1 : 0;
            nctr = 2;
            ntgt = bus.ex_target;
        end
    endfunction

    always @(posedge clk) begin
        bit wr, h1, h2;
        int way, nctr, s;
        logic [31:0] ntgt;
        if (!rst_n) begin
            for (int w = 0; w < 2; w++)
                for (int k = 0; k < 8; k++) begin
                    m_valid[w][k] = 1'b0;
                    m_ctr[w][k]   = 0;
                end
            m_busy_left = 0;
            m_init = 1;
        end else if (m_init) begin
            if (m_busy_left > 0) begin
                m_busy_left = bus.flush ? 8 : m_busy_left - 1;
            end else begin
                model_ex(wr, way, nctr, ntgt, h1, h2);
                if (wr) begin
                    s = int'(bus.ex_pc[4:2]);
                    m_valid[way][s] = 1'b1;
                    m_tag[way][s]   = bus.ex_pc[31:5];
                    m_tgt[way][s]   = ntgt;
                    m_ctr[way][s]   = nctr;
                end
                if (bus.flush) begin
                    for (int w = 0; w < 2; w++)
                        for (int k = 0; k < 8; k++) m_valid[w][k] = 1'b0;
                    m_busy_left = 8;
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        bit wr, h1, h2, en, hit;
        int way, nctr, s, hway, hctr;
        logic [31:0] ntgt, htgt;
        if (m_init && rst_n) begin
            s    = int'(bus.if_pc[4:2]);
            en   = bus.if_valid && (m_busy_left == 0);
            model_ex(wr, way, nctr, ntgt, h1, h2);
            hit = 0; hway = 0; hctr = 0; htgt = 32'h0;
            if (en && m_valid[0][s] && m_tag[0][s] == bus.if_pc[31:5]) begin
                hit = 1; hway = 0; hctr = m_ctr[0][s]; htgt = m_tgt[0][s];
            end else if (en && m_valid[1][s] && m_tag[1][s] == bus.if_pc[31:5]) begin
                hit = 1; hway = 1; hctr = m_ctr[1][s]; htgt = m_tgt[1][s];
            end
`ifdef BTB_BYPASS_EN
            if (en && wr && bus.ex_pc[31:2] == bus.if_pc[31:2]) begin
                hit = 1; hway = way; hctr = nctr; htgt = ntgt;
            end
`endif
            chk("m_hit",    32'(bus.predict_hit),    32'(hit));
            chk("m_taken",  32'(bus.predict_taken),  32'(hit && hctr >= 2));
            chk("m_target", bus.predict_target,      htgt);
            chk("m_rd_idx", 32'(bus.read_index),     32'(s));
            chk("m_b1",     32'(bus.branch1_used),   32'(hit && hway == 0));
            chk("m_b2",     32'(bus.branch2_used),   32'(hit && hway == 1));
            chk("m_update", 32'(bus.update),         32'(wr));
            chk("m_up_idx", 32'(bus.update_index),   32'(bus.ex_pc[4:2]));
            chk("m_ub1",    32'(bus.update_branch1), 32'(h1));
            chk("m_ub2",    32'(bus.update_branch2), 32'(h2));
            chk("m_busy",   32'(bus.flush_busy),     32'(m_busy_left > 0));
            chk("m_state",  32'(dbg_state),          32'(m_busy_left > 0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input logic ifv, input logic [31:0] ipc, input logic exv,
                       input logic [31:0] epc, input logic tk, input logic [31:0] tgt,
                       input logic lru, input logic fl);
        @(posedge clk);
        #1;
        bus.if_valid = ifv;  bus.if_pc = ipc;
        bus.ex_valid = exv;  bus.ex_pc = epc; bus.ex_taken = tk; bus.ex_target = tgt;
        bus.lru_write_bit = lru;
        bus.flush = fl;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic look(input logic [31:0] pc);
        cyc(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // ---------------- directed stimulus with literal expectations ----------------
    initial begin
        int nb;
        bus.if_valid = 0; bus.if_pc = 0; bus.ex_valid = 0; bus.ex_pc = 0;
        bus.ex_taken = 0; bus.ex_target = 0; bus.lru_write_bit = 0; bus.flush = 0;
        rst_n = 1'b0;
        idle();
        idle();
        chk("rst_busy",   32'(bus.flush_busy), 32'h0);
        chk("rst_update", 32'(bus.update),     32'h0);
        rst_n = 1'b1;

        look(32'h100);
        chk("miss_hit", 32'(bus.predict_hit), 32'h0);
        chk("miss_tgt", bus.predict_target,   32'h0);
        chk("miss_b1",  32'(bus.branch1_used), 32'h0);
        chk("miss_b2",  32'(bus.branch2_used), 32'h0);

        cyc(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h400, 1'b0, 1'b0);
        chk("alloc1_upd", 32'(bus.update),         32'h1);
        chk("alloc1_ub1", 32'(bus.update_branch1), 32'h0);

        cyc(1'b1, 32'h100, 1'b1, 32'h120, 1'b1, 32'h800, 1'b1, 1'b0);
        chk("hit1_hit",   32'(bus.predict_hit),    32'h1);
        chk("hit1_taken", 32'(bus.predict_taken),  32'h1);
        chk("hit1_tgt",   bus.predict_target,      32'h400);
        chk("hit1_b1",    32'(bus.branch1_used),   32'h1);
        chk("alloc2_ub2", 32'(bus.update_branch2), 32'h0);

        cyc(1'b1, 32'h120, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("hit2_b2",  32'(bus.branch2_used),   32'h1);
        chk("hit2_tgt", bus.predict_target,      32'h800);
        chk("nt1_ub1",  32'(bus.update_branch1), 32'h1);

        cyc(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("ctr01_taken", 32'(bus.predict_taken), 32'h0);
        chk("nt2_ub1",     32'(bus.update_branch1), 32'h1);

        cyc(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("nt3_ub1", 32'(bus.update_branch1), 32'h1);

        cyc(1'b1, 32'h100, 1'b1, 32'h120, 1'b1, 32'h900, 1'b0, 1'b0);
        chk("ctr00_taken", 32'(bus.predict_taken), 32'h0);
        chk("ctr00_tgt",   bus.predict_target,     32'h400);
        chk("tk_ub2",      32'(bus.update_branch2), 32'h1);

        cyc(1'b1, 32'h120, 1'b1, 32'h160, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("ctr11_tgt",  bus.predict_target,     32'h900);
        chk("ntmiss_upd", 32'(bus.update),        32'h0);

        cyc(1'b1, 32'h160, 1'b1, 32'h104, 1'b1, 32'h200, 1'b0, 1'b0);
        chk("set1_upidx", 32'(bus.update_index), 32'h1);
        look(32'h104);
        chk("set1_hit", bus.predict_target, 32'h200);
        chk("set1_idx", 32'(bus.read_index), 32'h1);

        // Flush: busy starts the cycle after the pulse and lasts 8 cycles.
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("fl_pulse_busy", 32'(bus.flush_busy), 32'h0);
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 32'h100, (i == 3), 32'h180, 1'b1, 32'h700, 1'b0, 1'b0);
            if (bus.flush_busy === 1'b1) nb++;
            if (i == 0) chk("fl_first_busy", 32'(bus.flush_busy), 32'h1);
            if (i == 3) begin
                chk("fl_drop_upd", 32'(bus.update),      32'h0);
                chk("fl_busy_hit", 32'(bus.predict_hit), 32'h0);
            end
        end
        chk("fl_len", 32'(nb), 32'd8);
        look(32'h100);  chk("post_fl_100", 32'(bus.predict_hit), 32'h0);
        look(32'h120);  chk("post_fl_120", 32'(bus.predict_hit), 32'h0);
        look(32'h104);  chk("post_fl_104", 32'(bus.predict_hit), 32'h0);
        look(32'h180);  chk("post_fl_180", 32'(bus.predict_hit), 32'h0);

        // Same-cycle IF and EX allocate to the same entry.
        cyc(1'b1, 32'h140, 1'b1, 32'h140, 1'b1, 32'hA00, 1'b0, 1'b0);
`ifdef BTB_BYPASS_EN
        chk("byp_hit", 32'(bus.predict_hit),  32'h1);
        chk("byp_tgt", bus.predict_target,    32'hA00);
        chk("byp_b1",  32'(bus.branch1_used), 32'h1);
`else
        chk("nobyp_hit", 32'(bus.predict_hit), 32'h0);
        chk("nobyp_tgt", bus.predict_target,   32'h0);
`endif
        look(32'h140);
        chk("after_alloc_tgt", bus.predict_target, 32'hA00);

        // Flush re-asserted while busy restarts the 8-cycle walk.
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle();
        idle();
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("restart_busy", 32'(bus.flush_busy), 32'h1);
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            idle();
            if (bus.flush_busy === 1'b1) nb++;
        end
        chk("restart_len", 32'(nb), 32'd8);

        // Reset in the middle of a walk.
        cyc(1'b0, 32'h0, 1'b1, 32'h140, 1'b1, 32'hB00, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        idle();
        idle();
        rst_n = 1'b0;
        look(32'h140);
        chk("rstfl_busy", 32'(bus.flush_busy),  32'h0);
        chk("rstfl_hit",  32'(bus.predict_hit), 32'h0);
        rst_n = 1'b1;
        look(32'h140);
        chk("rstfl_after_hit",  32'(bus.predict_hit), 32'h0);
        chk("rstfl_after_busy", 32'(bus.flush_busy),  32'h0);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
